// File: rtl/prbs_lfsr_gen.sv
// rtl/prbs_lfsr_gen.sv - Parametrised Fibonacci LFSR generator, OUT_BITS steps per enabled clock
module prbs_lfsr_gen #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = 4'h3,
    parameter logic [WIDTH-1:0] SEED     = 4'hF,
    parameter int               OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed_in,
    output logic [OUT_BITS-1:0] rand_out,
    output logic                rand_vld,
    output logic [WIDTH-1:0]    state_out,
    output logic                wrap,
    output logic                lockup
);

    logic [WIDTH-1:0]    state;
    logic [WIDTH-1:0]    start;
    logic [WIDTH-1:0]    stepped;
    logic [OUT_BITS-1:0] bits;

    // Unrolled chain of OUT_BITS single steps; bit i is the LSB before step i.
    always_comb begin
        stepped = state;
        bits    = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            bits[i] = stepped[0];
            stepped = {^(stepped & TAPS), stepped[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEED;
            start    <= SEED;
            rand_out <= '0;
            rand_vld <= 1'b0;
            wrap     <= 1'b0;
            lockup   <= 1'b0;
        end else if (load) begin
            rand_vld <= 1'b0;
            wrap     <= 1'b0;
            if (seed_in == '0) begin
                // An all-zero state would never leave zero; substitute the default seed.
                state  <= SEED;
                start  <= SEED;
                lockup <= 1'b1;
            end else begin
                state  <= seed_in;
                start  <= seed_in;
                lockup <= 1'b0;
            end
        end else if (en) begin
            state    <= stepped;
            rand_out <= bits;
            rand_vld <= 1'b1;
            wrap     <= (stepped == start);
            lockup   <= 1'b0;
        end else begin
            rand_vld <= 1'b0;
            wrap     <= 1'b0;
            lockup   <= 1'b0;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// tb/tb_prbs_lfsr_gen.sv - Directed self-checking bench for prbs_lfsr_gen
module tb_prbs_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset, en, load;
    logic [3:0] seed_in;
    logic [0:0] rand_out;
    logic       rand_vld, wrap, lockup;
    logic [3:0] state_out;

    logic       reset4, en4, load4;
    logic [3:0] seed4;
    logic [3:0] rand_out4;
    logic       rand_vld4, wrap4, lockup4;
    logic [3:0] state_out4;

    int compared = 0;
    int mismatched = 0;

    logic [3:0] st_tab [15];
    logic       bit_tab [15];

    always #5 clk = ~clk;

    prbs_lfsr_gen u_dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
        .rand_out(rand_out), .rand_vld(rand_vld), .state_out(state_out),
        .wrap(wrap), .lockup(lockup)
    );

    prbs_lfsr_gen #(.OUT_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset4), .en(en4), .load(load4), .seed_in(seed4),
        .rand_out(rand_out4), .rand_vld(rand_vld4), .state_out(state_out4),
        .wrap(wrap4), .lockup(lockup4)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; load = 1'b0; seed_in = 4'h0;
        cycle();
        compared++;
        if (state_out !== 4'hF) begin
            mismatched++; $display("FAIL reset_state got %h want F", state_out);
        end
        compared++;
        if ({rand_out, rand_vld, wrap, lockup} !== 4'b0000) begin
            mismatched++; $display("FAIL reset_flags got %b want 0000", {rand_out, rand_vld, wrap, lockup});
        end
    endtask

    task automatic test_sequence();
        reset = 1'b0; en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cycle();
            compared++;
            if ({rand_out, rand_vld, wrap, state_out} !== {bit_tab[i], 1'b1, (i == 14), st_tab[(i + 1) % 15]}) begin
                mismatched++;
                $display("FAIL seq[%0d] got bit=%b vld=%b wrap=%b st=%h want bit=%b vld=1 wrap=%b st=%h",
                         i, rand_out, rand_vld, wrap, state_out, bit_tab[i], (i == 14), st_tab[(i + 1) % 15]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_multi_bit();
        reset4 = 1'b1; en4 = 1'b0; load4 = 1'b0; seed4 = 4'h0;
        cycle();
        reset4 = 1'b0; en4 = 1'b1;
        cycle();
        compared++;
        if ({rand_out4, state_out4, rand_vld4} !== {4'hF, 4'h8, 1'b1}) begin
            mismatched++; $display("FAIL multi1 got out=%h st=%h vld=%b want F 8 1", rand_out4, state_out4, rand_vld4);
        end
        cycle();
        compared++;
        if ({rand_out4, state_out4, rand_vld4} !== {4'h8, 4'hC, 1'b1}) begin
            mismatched++; $display("FAIL multi2 got out=%h st=%h vld=%b want 8 C 1", rand_out4, state_out4, rand_vld4);
        end
        en4 = 1'b0;
        cycle();
        compared++;
        if ({rand_out4, state_out4, rand_vld4} !== {4'h8, 4'hC, 1'b0}) begin
            mismatched++; $display("FAIL multi_hold got out=%h st=%h vld=%b want 8 C 0", rand_out4, state_out4, rand_vld4);
        end
    endtask

    task automatic test_lockup();
        logic [0:0] prev;
        prev = rand_out;
        load = 1'b1; seed_in = 4'h0; en = 1'b0;
        cycle();
        compared++;
        if ({state_out, lockup, rand_vld, rand_out} !== {4'hF, 1'b1, 1'b0, prev}) begin
            mismatched++; $display("FAIL lockup_load got st=%h lk=%b vld=%b out=%b want F 1 0 %b",
                                   state_out, lockup, rand_vld, rand_out, prev);
        end
        load = 1'b0;
        cycle();
        compared++;
        if ({lockup, state_out} !== {1'b0, 4'hF}) begin
            mismatched++; $display("FAIL lockup_pulse got lk=%b st=%h want 0 F", lockup, state_out);
        end
        en = 1'b1;
        cycle();
        compared++;
        if ({rand_out, rand_vld, state_out} !== {1'b1, 1'b1, 4'h7}) begin
            mismatched++; $display("FAIL lockup_next got out=%b vld=%b st=%h want 1 1 7", rand_out, rand_vld, state_out);
        end
        en = 1'b0;
    endtask

    task automatic test_load_over_en();
        load = 1'b1; en = 1'b1; seed_in = 4'h9;
        cycle();
        compared++;
        if ({state_out, rand_vld, wrap, lockup} !== {4'h9, 1'b0, 1'b0, 1'b0}) begin
            mismatched++; $display("FAIL load_en got st=%h vld=%b wrap=%b lk=%b want 9 0 0 0", state_out, rand_vld, wrap, lockup);
        end
        load = 1'b0;
        cycle();
        compared++;
        if ({rand_out, state_out} !== {1'b1, 4'hC}) begin
            mismatched++; $display("FAIL load_first got out=%b st=%h want 1 C", rand_out, state_out);
        end
        for (int k = 2; k <= 15; k++) begin
            cycle();
            compared++;
            if ({state_out, wrap} !== {st_tab[(7 + k) % 15], (k == 15)}) begin
                mismatched++; $display("FAIL load_wrap[%0d] got st=%h wrap=%b want %h %b",
                                       k, state_out, wrap, st_tab[(7 + k) % 15], (k == 15));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_en_gaps();
        logic       pat [4];
        logic [3:0] st_exp [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        st_exp = '{4'h7, 4'h7, 4'h7, 4'h3};
        reset = 1'b1; en = 1'b0;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en = pat[i];
            cycle();
            compared++;
            if ({rand_vld, rand_out, state_out} !== {pat[i], 1'b1, st_exp[i]}) begin
                mismatched++; $display("FAIL gaps[%0d] got vld=%b out=%b st=%h want %b 1 %h",
                                       i, rand_vld, rand_out, state_out, pat[i], st_exp[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1;
        cycle();
        reset = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        compared++;
        if (state_out !== 4'hB) begin
            mismatched++; $display("FAIL mid_pre got st=%h want B", state_out);
        end
        reset = 1'b1;
        cycle();
        compared++;
        if ({state_out, rand_out, rand_vld, wrap, lockup} !== {4'hF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            mismatched++; $display("FAIL mid_reset got st=%h out=%b vld=%b wrap=%b lk=%b want F 0 0 0 0",
                                   state_out, rand_out, rand_vld, wrap, lockup);
        end
        reset = 1'b0;
        cycle();
        compared++;
        if ({state_out, rand_out, rand_vld} !== {4'h7, 1'b1, 1'b1}) begin
            mismatched++; $display("FAIL mid_restart got st=%h out=%b vld=%b want 7 1 1", state_out, rand_out, rand_vld);
        end
        en = 1'b0;
    endtask

    initial begin
        st_tab  = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2, 4'h9,
                    4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE};
        bit_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        reset4 = 1'b1; en4 = 1'b0; load4 = 1'b0; seed4 = 4'h0;
        test_reset();
        test_sequence();
        test_multi_bit();
        test_lockup();
        test_load_over_en();
        test_en_gaps();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
